// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: BHT counter encodings and PC step.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = WNT;
    localparam int         PC_INC    = 4;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bht_state_e i_cur,
    input  logic       i_taken,
    output bht_state_e o_next
);

    always_comb begin
        o_next = i_cur;
        case (i_cur)
            SNT:     o_next = i_taken ? WNT : SNT;
            WNT:     o_next = i_taken ? WT  : SNT;
            WT:      o_next = i_taken ? ST  : WNT;
            ST:      o_next = i_taken ? ST  : WT;
            default: o_next = i_cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB branch predictor with execute-side redirect and perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int TAG_W = XLEN - 2 - IDX_W,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [XLEN-1:0]  i_pc_f,
    output logic             o_pred_taken_f,
    output logic [XLEN-1:0]  o_pred_target_f,
    input  logic             i_valid_e,
    input  logic             i_stall_e,
    input  logic             i_branch_e,
    input  logic             i_branch_taken_e,
    input  logic [XLEN-1:0]  i_pc_e,
    input  logic [XLEN-1:0]  i_target_e,
    input  logic             i_pred_taken_e,
    input  logic [XLEN-1:0]  i_pred_target_e,
    output logic             o_mispredict_e,
    output logic [XLEN-1:0]  o_correct_pc_e,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispredict_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    bht_state_e       r_bht    [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [XLEN-1:0]  r_target [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic [IDX_W-1:0] w_idx_f;
    logic [TAG_W-1:0] w_tag_f;
    logic             w_hit_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_e;
    logic             w_res;
    logic             w_mispredict;
    logic             w_match_e;
    logic             w_replace_e;
    logic             w_cnt_upd_e;
    bht_state_e       w_bht_next;
    logic             w_unused;

    assign w_unused = &{1'b0, i_pc_f[1:0], i_pc_e[1:0]};

    // Fetch lookup reads pre-edge state only; there is no bypass from execute.
    assign w_idx_f         = i_pc_f[IDX_W+1:2];
    assign w_tag_f         = i_pc_f[XLEN-1:IDX_W+2];
    assign w_hit_f         = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign o_pred_taken_f  = w_hit_f && r_bht[w_idx_f][1];
    assign o_pred_target_f = o_pred_taken_f ? r_target[w_idx_f] : '0;

    assign w_res        = i_valid_e && i_branch_e && !i_stall_e;
    assign w_mispredict = w_res && ((i_branch_taken_e != i_pred_taken_e) ||
                                    (i_branch_taken_e && (i_pred_target_e != i_target_e)));
    assign o_mispredict_e = w_mispredict;
    assign o_correct_pc_e = !w_mispredict  ? '0 :
                            i_branch_taken_e ? i_target_e :
                                               i_pc_e + XLEN'(PC_INC);

    assign w_idx_e     = i_pc_e[IDX_W+1:2];
    assign w_tag_e     = i_pc_e[XLEN-1:IDX_W+2];
    assign w_match_e   = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
    // A not-taken alias must not evict a live entry.
    assign w_replace_e = r_valid[w_idx_e] && !w_match_e && i_branch_taken_e;
    assign w_cnt_upd_e = w_match_e || (!r_valid[w_idx_e] && i_branch_taken_e);

    sat_counter2 u_sat_counter2 (
        .i_cur   (r_bht[w_idx_e]),
        .i_taken (i_branch_taken_e),
        .o_next  (w_bht_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid          <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_bht[i] <= BHT_RESET;
            end
        end else if (w_res) begin
            if (i_branch_taken_e) begin
                r_valid[w_idx_e] <= 1'b1;
            end
            if (w_replace_e) begin
                r_bht[w_idx_e] <= WT;
            end else if (w_cnt_upd_e) begin
                r_bht[w_idx_e] <= w_bht_next;
            end
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    // Tag and target are qualified by r_valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (w_res && i_branch_taken_e) begin
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= i_target_e;
        end
    end

    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic vs a table model.
module tb_branch_predictor;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_pc_f;
    logic        i_valid_e, i_stall_e, i_branch_e, i_branch_taken_e, i_pred_taken_e;
    logic [31:0] i_pc_e, i_target_e, i_pred_target_e;

    logic        o_pred_taken_f, o_mispredict_e;
    logic [31:0] o_pred_target_f, o_correct_pc_e, o_branch_cnt, o_mispredict_cnt;

    logic        s_pred_taken_f, s_mispredict_e;
    logic [31:0] s_pred_target_f, s_correct_pc_e;
    logic [3:0]  s_branch_cnt, s_mispredict_cnt;

    int passed = 0;
    int total  = 0;

    branch_predictor dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_f(i_pc_f),
        .o_pred_taken_f(o_pred_taken_f), .o_pred_target_f(o_pred_target_f),
        .i_valid_e(i_valid_e), .i_stall_e(i_stall_e), .i_branch_e(i_branch_e),
        .i_branch_taken_e(i_branch_taken_e), .i_pc_e(i_pc_e), .i_target_e(i_target_e),
        .i_pred_taken_e(i_pred_taken_e), .i_pred_target_e(i_pred_target_e),
        .o_mispredict_e(o_mispredict_e), .o_correct_pc_e(o_correct_pc_e),
        .o_branch_cnt(o_branch_cnt), .o_mispredict_cnt(o_mispredict_cnt)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc_f(i_pc_f),
        .o_pred_taken_f(s_pred_taken_f), .o_pred_target_f(s_pred_target_f),
        .i_valid_e(i_valid_e), .i_stall_e(i_stall_e), .i_branch_e(i_branch_e),
        .i_branch_taken_e(i_branch_taken_e), .i_pc_e(i_pc_e), .i_target_e(i_target_e),
        .i_pred_taken_e(i_pred_taken_e), .i_pred_target_e(i_pred_target_e),
        .o_mispredict_e(s_mispredict_e), .o_correct_pc_e(s_correct_pc_e),
        .o_branch_cnt(s_branch_cnt), .o_mispredict_cnt(s_mispredict_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: each table slot holds a confidence level 0..3 (>=2 predicts taken).
    bit          m_valid  [64];
    logic [23:0] m_tag    [64];
    logic [31:0] m_target [64];
    int          m_conf   [64];
    int          m_br;
    int          m_mp;

    function automatic int idx_of(logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic bit m_pred_taken(logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == pc[31:8]) && (m_conf[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(logic [31:0] pc);
        return m_pred_taken(pc) ? m_target[idx_of(pc)] : 32'h0;
    endfunction

    function automatic bit m_res();
        return i_valid_e && i_branch_e && !i_stall_e;
    endfunction

    function automatic bit m_misp();
        if (!m_res()) return 1'b0;
        if (i_branch_taken_e != i_pred_taken_e) return 1'b1;
        return i_branch_taken_e && (i_pred_target_e != i_target_e);
    endfunction

    function automatic logic [31:0] m_cpc();
        if (!m_misp()) return 32'h0;
        return i_branch_taken_e ? i_target_e : i_pc_e + 32'd4;
    endfunction

    function automatic int sat15(int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_conf[i]  = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic m_train();
        int  i;
        bit  same;
        if (!m_res()) return;
        m_br++;
        if (m_misp()) m_mp++;
        i    = idx_of(i_pc_e);
        same = m_valid[i] && (m_tag[i] == i_pc_e[31:8]);
        if (same || !m_valid[i]) begin
            if (i_branch_taken_e) m_conf[i] = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
            else if (same)        m_conf[i] = (m_conf[i] > 0) ? m_conf[i] - 1 : 0;
        end else if (i_branch_taken_e) begin
            m_conf[i] = 2;
        end
        if (i_branch_taken_e) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = i_pc_e[31:8];
            m_target[i] = i_target_e;
        end
    endtask

    task automatic drive_e(bit v, bit st, bit br, bit tk, logic [31:0] pc,
                           logic [31:0] tgt, bit ptk, logic [31:0] ptgt);
        i_valid_e        = v;
        i_stall_e        = st;
        i_branch_e       = br;
        i_branch_taken_e = tk;
        i_pc_e           = pc;
        i_target_e       = tgt;
        i_pred_taken_e   = ptk;
        i_pred_target_e  = ptgt;
    endtask

    task automatic idle_e();
        drive_e(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic tick();
        m_train();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle_e();
        i_pc_f = 32'h100;
        m_reset();
        #3;
        total++; if (o_pred_taken_f !== 1'b0) $display("FAIL reset_pred_taken got %0b exp 0", o_pred_taken_f); else passed++;
        total++; if (o_pred_target_f !== 32'h0) $display("FAIL reset_pred_target got %h exp 0", o_pred_target_f); else passed++;
        total++; if (o_branch_cnt !== 32'h0) $display("FAIL reset_branch_cnt got %0d exp 0", o_branch_cnt); else passed++;
        total++; if (o_mispredict_cnt !== 32'h0) $display("FAIL reset_mispredict_cnt got %0d exp 0", o_mispredict_cnt); else passed++;
        total++; if (o_mispredict_e !== 1'b0) $display("FAIL reset_mispredict got %0b exp 0", o_mispredict_e); else passed++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_basic();
        i_pc_f = 32'h100;
        drive_e(1, 0, 1, 1, 32'h100, 32'h140, 0, 32'h0);
        #1;
        total++; if (o_mispredict_e !== 1'b1) $display("FAIL first_taken_misp got %0b exp 1", o_mispredict_e); else passed++;
        total++; if (o_correct_pc_e !== 32'h140) $display("FAIL first_taken_cpc got %h exp 140", o_correct_pc_e); else passed++;
        tick();
        idle_e();
        #1;
        total++; if (o_pred_taken_f !== 1'b1) $display("FAIL learned_pred got %0b exp 1", o_pred_taken_f); else passed++;
        total++; if (o_pred_target_f !== 32'h140) $display("FAIL learned_target got %h exp 140", o_pred_target_f); else passed++;
        for (int k = 0; k < 3; k++) begin
            drive_e(1, 0, 1, 1, 32'h100, 32'h140, 1, 32'h140);
            #1;
            total++; if (o_mispredict_e !== 1'b0) $display("FAIL correct_taken_misp iter %0d got %0b exp 0", k, o_mispredict_e); else passed++;
            tick();
        end
        drive_e(1, 0, 1, 0, 32'h100, 32'h140, 1, 32'h140);
        #1;
        total++; if (o_mispredict_e !== 1'b1) $display("FAIL nt_after_st_misp got %0b exp 1", o_mispredict_e); else passed++;
        total++; if (o_correct_pc_e !== 32'h104) $display("FAIL nt_after_st_cpc got %h exp 104", o_correct_pc_e); else passed++;
        tick();
        idle_e();
        #1;
        total++; if (o_pred_taken_f !== 1'b1) $display("FAIL st_hysteresis_pred got %0b exp 1", o_pred_taken_f); else passed++;
        drive_e(1, 0, 1, 0, 32'h100, 32'h140, 1, 32'h140);
        tick();
        idle_e();
        #1;
        total++; if (o_pred_taken_f !== 1'b0) $display("FAIL wnt_pred got %0b exp 0", o_pred_taken_f); else passed++;
        drive_e(1, 0, 1, 1, 32'h100, 32'h180, 1, 32'h140);
        #1;
        total++; if (o_mispredict_e !== 1'b1) $display("FAIL target_miss_misp got %0b exp 1", o_mispredict_e); else passed++;
        total++; if (o_correct_pc_e !== 32'h180) $display("FAIL target_miss_cpc got %h exp 180", o_correct_pc_e); else passed++;
        tick();
        idle_e();
        #1;
        total++; if (o_pred_target_f !== 32'h180) $display("FAIL retarget got %h exp 180", o_pred_target_f); else passed++;
        drive_e(1, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h40);
        #1;
        total++; if (o_mispredict_e !== 1'b1) $display("FAIL wrap_misp got %0b exp 1", o_mispredict_e); else passed++;
        total++; if (o_correct_pc_e !== 32'h0) $display("FAIL wrap_cpc got %h exp 0", o_correct_pc_e); else passed++;
        tick();
        drive_e(1, 0, 0, 1, 32'h100, 32'h900, 0, 32'h0);
        #1;
        total++; if (o_mispredict_e !== 1'b0) $display("FAIL non_branch_misp got %0b exp 0", o_mispredict_e); else passed++;
        tick();
        idle_e();
        #1;
        total++; if (o_pred_target_f !== 32'h180) $display("FAIL non_branch_no_train got %h exp 180", o_pred_target_f); else passed++;
        total++; if (o_branch_cnt !== 32'(m_br)) $display("FAIL basic_branch_cnt got %0d exp %0d", o_branch_cnt, m_br); else passed++;
        total++; if (o_mispredict_cnt !== 32'(m_mp)) $display("FAIL basic_misp_cnt got %0d exp %0d", o_mispredict_cnt, m_mp); else passed++;
    endtask

    task automatic test_alias();
        drive_e(1, 0, 1, 1, 32'h200, 32'h300, 0, 32'h0);
        tick();
        idle_e();
        i_pc_f = 32'h100;
        #1;
        total++; if (o_pred_taken_f !== 1'b0) $display("FAIL alias_old_pred got %0b exp 0", o_pred_taken_f); else passed++;
        i_pc_f = 32'h200;
        #1;
        total++; if (o_pred_taken_f !== 1'b1) $display("FAIL alias_new_pred got %0b exp 1", o_pred_taken_f); else passed++;
        total++; if (o_pred_target_f !== 32'h300) $display("FAIL alias_new_target got %h exp 300", o_pred_target_f); else passed++;
        drive_e(1, 0, 1, 0, 32'h100, 32'h140, 0, 32'h0);
        tick();
        idle_e();
        #1;
        total++; if (o_pred_target_f !== 32'h300) $display("FAIL alias_nt_untouched got %h exp 300", o_pred_target_f); else passed++;
    endtask

    task automatic test_same_cycle();
        i_pc_f = 32'h200;
        drive_e(1, 0, 1, 0, 32'h200, 32'h300, 1, 32'h300);
        #1;
        total++; if (o_pred_taken_f !== 1'b1) $display("FAIL same_cycle_old got %0b exp 1", o_pred_taken_f); else passed++;
        tick();
        idle_e();
        #1;
        total++; if (o_pred_taken_f !== 1'b0) $display("FAIL same_cycle_new got %0b exp 0", o_pred_taken_f); else passed++;
        i_pc_f = 32'h10C;
        drive_e(1, 0, 1, 1, 32'h10C, 32'h500, 0, 32'h0);
        #1;
        total++; if (o_pred_taken_f !== 1'b0) $display("FAIL alloc_old got %0b exp 0", o_pred_taken_f); else passed++;
        tick();
        idle_e();
        #1;
        total++; if (o_pred_target_f !== 32'h500) $display("FAIL alloc_new got %h exp 500", o_pred_target_f); else passed++;
        drive_e(1, 1, 1, 1, 32'h10C, 32'h600, 0, 32'h0);
        #1;
        total++; if (o_mispredict_e !== 1'b0) $display("FAIL stall_misp got %0b exp 0", o_mispredict_e); else passed++;
        total++; if (o_correct_pc_e !== 32'h0) $display("FAIL stall_cpc got %h exp 0", o_correct_pc_e); else passed++;
        tick();
        tick();
        idle_e();
        #1;
        total++; if (o_pred_target_f !== 32'h500) $display("FAIL stall_no_train got %h exp 500", o_pred_target_f); else passed++;
        total++; if (o_branch_cnt !== 32'(m_br)) $display("FAIL stall_branch_cnt got %0d exp %0d", o_branch_cnt, m_br); else passed++;
        total++; if (o_mispredict_cnt !== 32'(m_mp)) $display("FAIL stall_misp_cnt got %0d exp %0d", o_mispredict_cnt, m_mp); else passed++;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 20; k++) begin
            drive_e(1, 0, 1, k[0], 32'h3F0, 32'h800, ~k[0], 32'h800);
            tick();
            total++; if (s_mispredict_cnt !== 4'(sat15(m_mp))) $display("FAIL sat_misp_cnt iter %0d got %0d exp %0d", k, s_mispredict_cnt, sat15(m_mp)); else passed++;
        end
        total++; if (s_mispredict_cnt !== 4'd15) $display("FAIL sat_misp_final got %0d exp 15", s_mispredict_cnt); else passed++;
        total++; if (s_branch_cnt !== 4'd15) $display("FAIL sat_branch_final got %0d exp 15", s_branch_cnt); else passed++;
        total++; if (o_mispredict_cnt !== 32'(m_mp)) $display("FAIL wide_misp_cnt got %0d exp %0d", o_mispredict_cnt, m_mp); else passed++;
        i_pc_f = 32'h10C;
        drive_e(1, 0, 1, 1, 32'h10C, 32'h700, 0, 32'h0);
        #2;
        i_rst_n = 1'b0;
        m_reset();
        #1;
        total++; if (o_branch_cnt !== 32'h0) $display("FAIL midrst_branch_cnt got %0d exp 0", o_branch_cnt); else passed++;
        total++; if (o_mispredict_cnt !== 32'h0) $display("FAIL midrst_misp_cnt got %0d exp 0", o_mispredict_cnt); else passed++;
        total++; if (s_mispredict_cnt !== 4'h0) $display("FAIL midrst_sat_cnt got %0d exp 0", s_mispredict_cnt); else passed++;
        total++; if (o_pred_taken_f !== 1'b0) $display("FAIL midrst_valid got %0b exp 0", o_pred_taken_f); else passed++;
        @(posedge i_clk);
        #1;
        total++; if (o_branch_cnt !== 32'h0) $display("FAIL rst_override_cnt got %0d exp 0", o_branch_cnt); else passed++;
        total++; if (o_pred_taken_f !== 1'b0) $display("FAIL rst_override_valid got %0b exp 0", o_pred_taken_f); else passed++;
        i_rst_n = 1'b1;
        idle_e();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pc_f, pc_e;
        for (int n = 0; n < 400; n++) begin
            pc_f = {22'h0, 2'($urandom_range(1, 3)), 6'($urandom_range(0, 7)), 2'b00};
            pc_e = {22'h0, 2'($urandom_range(1, 3)), 6'($urandom_range(0, 7)), 2'b00};
            i_pc_f = pc_f;
            drive_e(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), pc_e,
                    32'h1000 + 32'($urandom_range(0, 3)) * 32'h40,
                    ($urandom_range(0, 1) != 0) ? m_pred_taken(pc_e) : 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0) ? m_pred_target(pc_e)
                                                : 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40);
            #1;
            total++; if (o_pred_taken_f !== m_pred_taken(pc_f)) $display("FAIL rnd_pred_taken n=%0d got %0b exp %0b", n, o_pred_taken_f, m_pred_taken(pc_f)); else passed++;
            total++; if (o_pred_target_f !== m_pred_target(pc_f)) $display("FAIL rnd_pred_target n=%0d got %h exp %h", n, o_pred_target_f, m_pred_target(pc_f)); else passed++;
            total++; if (o_mispredict_e !== m_misp()) $display("FAIL rnd_misp n=%0d got %0b exp %0b", n, o_mispredict_e, m_misp()); else passed++;
            total++; if (o_correct_pc_e !== m_cpc()) $display("FAIL rnd_cpc n=%0d got %h exp %h", n, o_correct_pc_e, m_cpc()); else passed++;
            total++; if (o_branch_cnt !== 32'(m_br)) $display("FAIL rnd_branch_cnt n=%0d got %0d exp %0d", n, o_branch_cnt, m_br); else passed++;
            total++; if (o_mispredict_cnt !== 32'(m_mp)) $display("FAIL rnd_misp_cnt n=%0d got %0d exp %0d", n, o_mispredict_cnt, m_mp); else passed++;
            total++; if (s_branch_cnt !== 4'(sat15(m_br))) $display("FAIL rnd_sat_branch_cnt n=%0d got %0d exp %0d", n, s_branch_cnt, sat15(m_br)); else passed++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alias();
        test_same_cycle();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and mispredict controller for the 5-stage pipeline.
- Fetch side: looks up the fetch PC in a direct-mapped table and supplies a predicted direction and target.
- Execute side: compares the prediction with the resolved outcome from the branch decision logic, raises a redirect request, and trains its tables.
- Maintains a branch history table (BHT) of 2-bit saturating counters, a branch target buffer (BTB) with tags, and performance counters.

Parameters:
- XLEN, 32, address/data width.
- IDX_W, 6, index bits; the table has 2**IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, XLEN-2-IDX_W, stored tag width; tag = pc[XLEN-1:IDX_W+2].
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pc_f  in  XLEN  fetch-stage PC.
- o_pred_taken_f  out  1  predicted taken; combinational from i_pc_f.
- o_pred_target_f  out  XLEN  predicted target; 0 when o_pred_taken_f=0.
- i_valid_e  in  1  a real (non-bubble, non-flushed) instruction is in execute.
- i_stall_e  in  1  execute is stalled; blocks training and counting.
- i_branch_e  in  1  instruction in execute is a conditional branch.
- i_branch_taken_e  in  1  resolved direction from the branch decision logic.
- i_pc_e  in  XLEN  PC of the instruction in execute.
- i_target_e  in  XLEN  computed branch target (pc_e + imm).
- i_pred_taken_e  in  1  prediction piped with the instruction from fetch.
- i_pred_target_e  in  XLEN  predicted target piped with the instruction from fetch.
- o_mispredict_e  out  1  redirect request: flush fetch/decode, load o_correct_pc_e.
- o_correct_pc_e  out  XLEN  redirect PC.
- o_branch_cnt  out  CNT_W  number of resolved branches.
- o_mispredict_cnt  out  CNT_W  number of mispredictions.

Behaviour:
Reset (asynchronous):
- All BHT counters reset to 2'b01 (weakly not-taken).
- All BTB valid bits cleared; tags/targets need not be reset.
- Both performance counters reset to 0.
- All outputs then evaluate to 0.

Lookup (combinational, zero latency):
- hit = valid[idx_f] && tag[idx_f]==tag_f.
- o_pred_taken_f = hit && bht[idx_f][1].
- o_pred_target_f = btb_target[idx_f] when o_pred_taken_f, else 0.

Resolution (combinational):
- Define res = i_valid_e && i_branch_e && !i_stall_e.
- o_mispredict_e = res && (i_branch_taken_e != i_pred_taken_e || (i_branch_taken_e && i_pred_target_e != i_target_e)).
- o_correct_pc_e = i_target_e when i_branch_taken_e, else i_pc_e + 4. Addition wraps modulo 2**XLEN.
- o_correct_pc_e = 0 when o_mispredict_e=0.
- Non-branch instructions (including jumps) never assert o_mispredict_e and never train the tables.

Training (at the clock edge when res=1; idx_e/tag_e are taken from i_pc_e):
- BTB allocation and target update happen only when i_branch_taken_e=1. Then valid[idx_e]<=1, tag[idx_e]<=tag_e, btb_target[idx_e]<=i_target_e.
- Tag mismatch on an existing valid entry:
  - Taken branch: replace the entry and set bht[idx_e]<=2'b10.
  - Not-taken branch: leave the BTB and BHT untouched.
- Tag match, or invalid entry with a taken branch: update the counter.
  - Taken: saturating increment, 11 stays 11.
  - Not-taken: saturating decrement, 00 stays 00.
- Counter sequence: 00->01->10->11 on taken; the reverse on not-taken.

Simultaneous lookup and update of the same index:
- Fetch sees the pre-edge (old) value.
- The written value is visible on the following cycle.
- No bypass.

Performance counters:
- o_branch_cnt increments when res=1.
- o_mispredict_cnt increments when o_mispredict_e=1.
- Both saturate at all-ones and do not wrap.

Stall and reset interaction:
- i_stall_e=1 freezes all state; outputs remain combinational.
- Reset asserted mid-operation overrides any pending update in that cycle.

Decomposition:
- Shared package header holds:
  - the BHT state encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the BHT reset value WNT;
  - the PC increment constant 4.
- The existing branch funct3 defines stay in the common defines header. This block does not decode funct3.
- One sub-module: sat_counter2, a pure combinational 2-bit saturating next-state function (inputs: cur, taken; output: next). It is instantiated once on the execute-side update path.

Test Plan:
1. Reset, then drive i_pc_f=0x100 -> o_pred_taken_f=0, o_pred_target_f=0; both counters 0.
2. Branch at pc 0x100 resolves taken to 0x140 with pred 0 -> o_mispredict_e=1, o_correct_pc_e=0x140. Next cycle i_pc_f=0x100 -> o_pred_taken_f=1, target 0x140; counter=10.
3. Same branch resolves taken three times -> counter 11 and stays 11. Then one not-taken with pred 1 -> o_mispredict_e=1, o_correct_pc_e=0x104; o_pred_taken_f still 1 (counter 10).
4. Aliasing: pc 0x100 entry valid, then pc 0x200 (same idx for IDX_W=6) resolves taken to 0x300 -> entry replaced, counter 10. Lookup at 0x100 -> o_pred_taken_f=0 (tag miss).
5. Same-cycle update of idx_e==idx_f -> fetch output reflects the old entry that cycle and the new entry the next cycle. Assert i_stall_e=1 with res inputs active -> no table change, no counter increment, o_mispredict_e=0.
6. Force o_mispredict_cnt to near saturation via a long mispredict sequence (CNT_W overridden to 4) -> count stops at 15. Assert i_rst_n low mid-stream -> immediate clear of all counters and valid bits.
